// File: rtl/sap_pkg.sv
// sap_pkg: widths and control-word bit positions shared across the SAP CPU blocks
package sap_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CTRL_L_MA = 0;
    localparam int CTRL_L_MD = 1;
    localparam int CTRL_CE   = 2;
    localparam int CTRL_L_R  = 3;
    localparam int CTRL_W    = 4;
endpackage

// File: rtl/sap_memory_block_if.sv
// sap_memory_block_if: bus, control strobes and programming port of the memory stage
interface sap_memory_block_if;
    import sap_pkg::*;
    logic [DATA_W-1:0] bus_in;
    logic              ctrl_mar_addr_load_n;
    logic              ctrl_mar_mem_load_n;
    logic              ctrl_ram_en_n;
    logic              ctrl_ram_load_n;
    logic [DATA_W-1:0] bus_out;
    logic              bus_out_en;
    logic              prog_mode;
    logic              prog_valid;
    logic [DATA_W-1:0] prog_data;
    logic              prog_ready;
    logic              prog_done;
    logic [ADDR_W-1:0] mar_addr;
    modport master (
        output bus_in, ctrl_mar_addr_load_n, ctrl_mar_mem_load_n, ctrl_ram_en_n, ctrl_ram_load_n,
        output prog_mode, prog_valid, prog_data,
        input  bus_out, bus_out_en, prog_ready, prog_done, mar_addr
    );
    modport slave (
        input  bus_in, ctrl_mar_addr_load_n, ctrl_mar_mem_load_n, ctrl_ram_en_n, ctrl_ram_load_n,
        input  prog_mode, prog_valid, prog_data,
        output bus_out, bus_out_en, prog_ready, prog_done, mar_addr
    );
endinterface

// File: rtl/sap_ram16x8.sv
// sap_ram16x8: unreset register-array RAM, synchronous write, asynchronous read
module sap_ram16x8
    import sap_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/sap_memory_block.sv
// sap_memory_block: MAR, MDR and 16x8 RAM of the SAP CPU, with a sequential programming port
module sap_memory_block
    import sap_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    sap_memory_block_if.slave  mb
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] mar;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] ram_q;
    logic              run;
    logic              accept;
    logic              we;

    assign run    = !mb.prog_mode;
    assign accept = mb.prog_ready && mb.prog_valid;
    // reset wins over any write request on the same edge, so RAM stays untouched
    assign we     = !rst && (run ? !mb.ctrl_ram_load_n : accept);

    sap_ram16x8 u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (run ? mar : ptr),
        .wdata (run ? mdr : mb.prog_data),
        .raddr (mar),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            mar   <= '0;
            mdr   <= '0;
        end else begin
            if (run && !mb.ctrl_mar_addr_load_n) mar <= mb.bus_in[ADDR_W-1:0];
            if (run && !mb.ctrl_mar_mem_load_n) mdr <= mb.bus_in;
            if (run) begin
                state <= IDLE;
                ptr   <= '0;
            end else if (state == IDLE) begin
                state <= LOAD;
                ptr   <= '0;
            end else if (accept) begin
                ptr <= ptr + 1'b1;
                if (ptr == ADDR_W'(DEPTH - 1)) state <= DONE;
            end
        end
    end

    assign mb.bus_out_en = !rst && run && !mb.ctrl_ram_en_n;
    assign mb.bus_out    = mb.bus_out_en ? ram_q : '0;
    assign mb.prog_ready = state == LOAD && mb.prog_mode;
    assign mb.prog_done  = state == DONE;
    assign mb.mar_addr   = mar;
endmodule

// File: doc/sap_memory_block.md
# sap_memory_block

Memory stage of the SAP-style CPU, directly downstream of the control block. It holds the 4-bit memory address register (MAR), the 8-bit memory data register (MDR) and a 16x8 RAM. It acts on the active-low MAR/RAM control strobes from the control block and drives RAM data onto the shared bus. A programming port with a valid/ready handshake fills the RAM sequentially before the CPU runs.

## Interface
- ADDR_W, 4, address width (MAR width)
- DATA_W, 8, word and bus width
- DEPTH, 16, RAM words; must equal 2**ADDR_W
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- bus_in  in  DATA_W  shared bus value
- ctrl_mar_addr_load_n  in  1  \L_MA: MAR <= bus_in[ADDR_W-1:0]
- ctrl_mar_mem_load_n  in  1  \L_MD: MDR <= bus_in
- ctrl_ram_en_n  in  1  \CE: drive RAM[MAR] onto bus
- ctrl_ram_load_n  in  1  \L_R: RAM[MAR] <= MDR
- bus_out  out  DATA_W  RAM[MAR] while bus_out_en, else 0
- bus_out_en  out  1  bus drive request
- prog_mode  in  1  selects programming mode
- prog_valid  in  1  prog_data is valid
- prog_data  in  DATA_W  word to write
- prog_ready  out  1  block accepts a word this cycle
- prog_done  out  1  all DEPTH words written
- mar_addr  out  ADDR_W  current MAR, for debug

## Operation
- Run mode (prog_mode=0). All four strobes are independent and each acts on the rising edge where it is low.
  - \L_MA low: MAR <= bus_in[3:0].
  - \L_MD low: MDR <= bus_in.
  - \L_R low: RAM[MAR] <= MDR, using the pre-edge MAR and MDR.
  - \CE low: bus_out = RAM[MAR] combinationally and bus_out_en=1.
- Simultaneous strobes:
  - \L_MA with \L_R: the write goes to the old MAR.
  - \L_MD with \L_R: the write uses the old MDR.
  - \CE with \L_R: bus_out shows the old contents in that cycle.
- Programming FSM, states IDLE, LOAD, DONE:
  - IDLE: prog_ready=0, prog_done=0. prog_mode=1 moves to LOAD and clears ptr to 0.
  - LOAD: prog_ready=1. prog_valid&&prog_ready writes RAM[ptr] <= prog_data and increments ptr.
  - LOAD: an accept at ptr==DEPTH-1 moves to DONE, and ptr wraps to 0.
  - LOAD: prog_mode=0 moves to IDLE. Any partial load stays in RAM and ptr clears.
  - DONE: prog_ready=0, prog_done=1. Further valids are ignored. prog_mode=0 moves to IDLE.
- While prog_mode=1 (any state):
  - All ctrl strobes are ignored.
  - MAR and MDR hold their values.
  - bus_out_en=0 and bus_out=0.
- Reset (rst=1 at an edge):
  - MAR=0, MDR=0, ptr=0, state IDLE.
  - Outputs: bus_out=0, bus_out_en=0, prog_ready=0, prog_done=0, mar_addr=0.
  - RAM contents are retained, so a program survives a CPU reset. Reset overrides any strobe or handshake on the same edge.
- Strobes are level-active each cycle. A strobe held low for N cycles performs N loads or writes.

## Timing
- Control strobes change after the falling clk edge and are sampled on the next rising edge, giving half a cycle of setup.
- MAR, MDR and RAM writes take effect one rising edge after the strobe.
- The read path (MAR to bus_out) is combinational, with zero-cycle latency from \CE.
- A RAM word written at edge k is readable from edge k onward, i.e. in the next cycle.
- prog_ready rises one cycle after prog_mode rises.
- One word is accepted per cycle at full throughput, so DEPTH words take DEPTH cycles.
- prog_done is registered and asserts in the cycle after the last accept.

## Structure
- Shared package `sap_pkg`: ADDR_W, DATA_W, DEPTH, and the control-bit index constants shared with the control block.
- Programming FSM state encoding is local to this block.
- One sub-module, `sap_ram16x8`: register-array RAM with a synchronous write port and an asynchronous read port. It is not reset.
- MAR, MDR, the programming FSM and the write-port mux (programming vs run) live in the top module.

## Test plan
- Reset: assert rst with all strobes low → MAR=0, MDR=0, bus_out_en=0, prog_ready=0. RAM written earlier is unchanged after reset.
- Programming: prog_mode=1, then stream words 0x10..0x1F with prog_valid=1 →
  - prog_ready=1 from cycle 1;
  - prog_done=1 after 16 accepts;
  - a 17th valid is ignored;
  - RAM[i]=0x10+i.
- Back-pressure and abort: stream with prog_valid toggling, then drop prog_mode after 5 accepts → RAM[0..4] written, RAM[5..] unchanged, FSM in IDLE. Re-entering programming starts again at address 0.
- Read: bus_in=0x07 with \L_MA low, then \CE low → bus_out=RAM[7], bus_out_en=1. With \CE high, bus_out=0.
- STA sequence:
  - \L_MA with bus 0x0E, then \L_MD with bus 0xA5, then \L_R → RAM[14]=0xA5.
  - The same-cycle \L_MA=0x03 with \L_R still writes to 14.
- Mode isolation: strobes low while prog_mode=1 → MAR, MDR and RAM are untouched by the strobes, and bus_out_en=0.
